// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding and
// the per-memory word sizes used to turn a word index into a byte address.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_IMEM = 3'd1,
    ST_LOAD_DMEM = 3'd2,
    ST_RUN       = 3'd3,
    ST_DUMP_RD   = 3'd4,
    ST_DUMP_CAP  = 3'd5,
    ST_DUMP_OUT  = 3'd6,
    ST_DONE      = 3'd7
  } state_e;

  localparam int IMEM_WORD_BYTES = 4;
  localparam int DMEM_WORD_BYTES = 8;
  localparam int IMEM_ADDR_SHIFT = $clog2(IMEM_WORD_BYTES);
  localparam int DMEM_ADDR_SHIFT = $clog2(DMEM_WORD_BYTES);

  // Byte address of a word index; no wrap, the index is already 64 bits wide.
  function automatic logic [63:0] word_addr(input logic [63:0] idx, input int shift);
    return idx << shift;
  endfunction

endpackage

// File: rtl/program_loader_counter.sv
// Loadable down-counter with a zero flag. Load wins over decrement and the
// count never goes below zero.
module program_loader_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load, saturating decrement, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/program_loader.sv
// Host-side sequencer in front of the cpu: streams an imem image and a dmem
// image in through one valid/ready port, runs the cpu for a programmed number
// of cycles, then reads back dmem words and streams them out.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [CNT_W-1:0] dump_words,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [63:0]      s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [63:0]      m_data,
  output logic             m_last,
  output logic             cpu_enable,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q;
  logic [CNT_W-1:0] idx_q;
  logic             err_q;
  logic             s_ready_q;
  logic             m_valid_q;
  logic             m_last_q;
  logic [63:0]      m_data_q;
  logic             cpu_enable_q;
  logic             busy_q;
  logic             done_q;

  logic             start_acc;
  logic             beat;
  logic             imem_beat;
  logic             dmem_beat;
  logic             imem_in_range;
  logic             dmem_in_range;
  logic             dump_clamp;
  logic [CNT_W-1:0] dump_load_val;
  logic [63:0]      idx_ext;
  logic [CNT_W-1:0] run_cnt;
  logic             run_zero;
  logic             run_dec;
  logic [CNT_W-1:0] dump_cnt;
  logic             dump_zero;
  logic             dump_dec;

  // Start is only honoured when no sequence is in flight.
  assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // A request for more words than dmem holds is clamped and flagged.
  assign dump_clamp    = (dump_words > CNT_W'(DMEM_DEPTH));
  assign dump_load_val = dump_clamp ? CNT_W'(DMEM_DEPTH) : dump_words;

  // s_ready is high exactly in the two load states, so it qualifies beats.
  assign beat      = s_valid && s_ready_q;
  assign imem_beat = beat && (state_q == ST_LOAD_IMEM);
  assign dmem_beat = beat && (state_q == ST_LOAD_DMEM);

  // Out-of-range beats are swallowed without touching memory.
  assign imem_in_range = (idx_q < CNT_W'(IMEM_DEPTH));
  assign dmem_in_range = (idx_q < CNT_W'(DMEM_DEPTH));

  assign idx_ext = 64'(idx_q);

  // Instruction memory port: write-only, driven straight from the beat.
  assign wen_ext   = imem_beat && imem_in_range;
  assign addr_ext  = wen_ext ? word_addr(idx_ext, IMEM_ADDR_SHIFT) : 64'd0;
  assign wdata_ext = wen_ext ? s_data[31:0] : 32'd0;
  assign ren_ext   = 1'b0;

  // Data memory port: writes during load, single-cycle reads during dump.
  assign wen_ext_2   = dmem_beat && dmem_in_range;
  assign ren_ext_2   = (state_q == ST_DUMP_RD);
  assign addr_ext_2  = (wen_ext_2 || ren_ext_2) ? word_addr(idx_ext, DMEM_ADDR_SHIFT) : 64'd0;
  assign wdata_ext_2 = wen_ext_2 ? s_data : 64'd0;

  // Counter strobes: one tick per RUN cycle, one per accepted dump word.
  assign run_dec  = (state_q == ST_RUN);
  assign dump_dec = (state_q == ST_DUMP_OUT) && m_ready;

  program_loader_counter #(
    .CNT_W (CNT_W)
  ) u_run_cnt (
    .clk        (clk),
    .arst_n     (arst_n),
    .load_i     (start_acc),
    .load_val_i (run_cycles),
    .dec_i      (run_dec),
    .count_o    (run_cnt),
    .zero_o     (run_zero)
  );

  program_loader_counter #(
    .CNT_W (CNT_W)
  ) u_dump_cnt (
    .clk        (clk),
    .arst_n     (arst_n),
    .load_i     (start_acc),
    .load_val_i (dump_load_val),
    .dec_i      (dump_dec),
    .count_o    (dump_cnt),
    .zero_o     (dump_zero)
  );

  // Sequencer FSM with registered status and stream outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      err_q        <= 1'b0;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= 64'd0;
      cpu_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_acc) begin
            state_q   <= ST_LOAD_IMEM;
            idx_q     <= '0;
            err_q     <= dump_clamp;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end

        ST_LOAD_IMEM: begin
          if (beat) begin
            if (!imem_in_range) begin
              err_q <= 1'b1;
            end
            if (s_last) begin
              idx_q   <= '0;
              state_q <= ST_LOAD_DMEM;
            end else begin
              idx_q <= idx_q + CNT_W'(1);
            end
          end
        end

        ST_LOAD_DMEM: begin
          if (beat) begin
            if (!dmem_in_range) begin
              err_q <= 1'b1;
            end
            if (s_last) begin
              idx_q     <= '0;
              s_ready_q <= 1'b0;
              if (!run_zero) begin
                state_q      <= ST_RUN;
                cpu_enable_q <= 1'b1;
              end else if (!dump_zero) begin
                state_q <= ST_DUMP_RD;
              end else begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + CNT_W'(1);
            end
          end
        end

        // The run counter hits zero on the last enabled cycle.
        ST_RUN: begin
          if (run_cnt == CNT_W'(1)) begin
            cpu_enable_q <= 1'b0;
            idx_q        <= '0;
            if (dump_zero) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_DUMP_RD;
            end
          end
        end

        ST_DUMP_RD: begin
          state_q <= ST_DUMP_CAP;
        end

        // Read data arrives one cycle after the read strobe.
        ST_DUMP_CAP: begin
          m_data_q  <= rdata_ext_2;
          m_valid_q <= 1'b1;
          m_last_q  <= (dump_cnt == CNT_W'(1));
          state_q   <= ST_DUMP_OUT;
        end

        ST_DUMP_OUT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            idx_q     <= idx_q + CNT_W'(1);
            if (m_last_q) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_DUMP_RD;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign m_data     = m_data_q;
  assign cpu_enable = cpu_enable_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: load/run/dump sequences, back-pressure,
// overflow, clamp, mid-run reset and a start pulse during loading.
module tb_program_loader;

  logic        clk;
  logic        arst_n;
  logic        start;
  logic [31:0] run_cycles;
  logic [31:0] dump_words;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_last;
  logic        cpu_enable;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [63:0] tb_mem [0:1023];

  program_loader dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .start       (start),
    .run_cycles  (run_cycles),
    .dump_words  (dump_words),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .cpu_enable  (cpu_enable),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model with one cycle of read latency.
  always @(posedge clk) begin
    if (wen_ext_2) tb_mem[addr_ext_2[12:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= tb_mem[addr_ext_2[12:3]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] rc, input logic [31:0] dw);
    run_cycles = rc;
    dump_words = dw;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // One load beat; checks the memory write it produces in the same cycle.
  task automatic beat(input string tag, input logic is_imem, input logic [63:0] d,
                      input logic last, input logic [63:0] exp_addr);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    #1;
    chk({tag, "_rdy"}, 64'(s_ready), 64'd1);
    if (is_imem) begin
      chk({tag, "_wen"}, 64'({wen_ext, wen_ext_2}), 64'd2);
      chk({tag, "_addr"}, addr_ext, exp_addr);
      chk({tag, "_wdata"}, 64'(wdata_ext), 64'(d[31:0]));
    end else begin
      chk({tag, "_wen"}, 64'({wen_ext, wen_ext_2}), 64'd1);
      chk({tag, "_addr"}, addr_ext_2, exp_addr);
      chk({tag, "_wdata"}, wdata_ext_2, d);
    end
    tick;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 64'd0;
  endtask

  // Receive one dump word, optionally stalling the consumer first.
  task automatic dump_word(input string tag, input logic [63:0] exp_raddr,
                           input logic [63:0] exp_d, input logic exp_l, input int stall);
    int n;
    int rens;
    int unstable;
    logic [63:0] raddr;
    n = 0;
    rens = 0;
    unstable = 0;
    raddr = '1;
    while (m_valid !== 1'b1 && n < 10) begin
      if (ren_ext_2 === 1'b1) begin
        rens++;
        raddr = addr_ext_2;
      end
      tick;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd2);
    chk({tag, "_ren"}, 64'(rens), 64'd1);
    chk({tag, "_raddr"}, raddr, exp_raddr);
    chk({tag, "_data"}, m_data, exp_d);
    chk({tag, "_last"}, 64'(m_last), 64'(exp_l));
    for (int k = 0; k < stall; k++) begin
      tick;
      if (m_valid !== 1'b1 || m_data !== exp_d || m_last !== exp_l ||
          busy !== 1'b1 || ren_ext_2 !== 1'b0) unstable++;
    end
    chk({tag, "_hold"}, 64'(unstable), 64'd0);
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    int words;
    int lastpos;

    arst_n = 1'b0;
    start = 1'b0;
    run_cycles = '0;
    dump_words = '0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    m_ready = 1'b0;

    // Reset state
    tick;
    tick;
    chk("rst_status", 64'({busy, done, err, s_ready, m_valid, m_last, cpu_enable}), 64'd0);
    chk("rst_ports", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
    chk("rst_mdata", m_data, 64'd0);
    arst_n = 1'b1;
    tick;

    // Basic load and dump, no run
    pulse_start(32'd0, 32'd2);
    chk("t1_busy", 64'({busy, done, s_ready}), 64'd5);
    beat("t1_i0", 1'b1, 64'h0000_0013, 1'b0, 64'd0);
    beat("t1_i1", 1'b1, 64'h0010_0093, 1'b0, 64'd4);
    beat("t1_i2", 1'b1, 64'h0020_8113, 1'b1, 64'd8);
    beat("t1_d0", 1'b0, 64'h5, 1'b0, 64'd0);
    beat("t1_d1", 1'b0, 64'hA, 1'b1, 64'd8);
    chk("t1_noenable", 64'(cpu_enable), 64'd0);
    dump_word("t1_w0", 64'd0, 64'h5, 1'b0, 0);
    dump_word("t1_w1", 64'd8, 64'hA, 1'b1, 0);
    chk("t1_done", 64'({done, busy, m_valid}), 64'd4);

    // Run for 7 cycles, then one stalled dump word
    pulse_start(32'd7, 32'd1);
    chk("t2_clr", 64'({done, busy}), 64'd1);
    beat("t2_i0", 1'b1, 64'h0000_0013, 1'b1, 64'd0);
    chk("t2_en_pre", 64'(cpu_enable), 64'd0);
    beat("t2_d0", 1'b0, 64'h77, 1'b1, 64'd0);
    chk("t2_en_first", 64'(cpu_enable), 64'd1);
    n = 0;
    while (cpu_enable === 1'b1 && n < 20) begin
      n++;
      tick;
    end
    chk("t2_en_len", 64'(n), 64'd7);
    dump_word("t2_w0", 64'd0, 64'h77, 1'b1, 10);
    chk("t2_done", 64'({done, busy}), 64'd2);

    // Imem overflow: 513 beats
    pulse_start(32'd0, 32'd0);
    bad = 0;
    for (int i = 0; i < 513; i++) begin
      s_valid = 1'b1;
      s_data = 64'(i);
      s_last = (i == 512);
      #1;
      if (i == 511) begin
        chk("t3_b511_addr", addr_ext, 64'h7FC);
        chk("t3_b511_err", 64'(err), 64'd0);
      end
      if (i == 512) begin
        chk("t3_b512_wen", 64'(wen_ext), 64'd0);
        chk("t3_b512_rdy", 64'(s_ready), 64'd1);
      end
      if (i < 512 && (wen_ext !== 1'b1 || addr_ext !== 64'(i) * 64'd4)) bad++;
      tick;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    chk("t3_pattern", 64'(bad), 64'd0);
    chk("t3_err", 64'(err), 64'd1);
    beat("t3_d0", 1'b0, 64'h1234, 1'b1, 64'd0);
    chk("t3_done_err", 64'({done, err}), 64'd3);

    // Reset in the middle of RUN
    pulse_start(32'd50, 32'd1);
    beat("t4_i0", 1'b1, 64'h13, 1'b1, 64'd0);
    beat("t4_d0", 1'b0, 64'h99, 1'b1, 64'd0);
    tick;
    tick;
    chk("t4_running", 64'({cpu_enable, busy}), 64'd3);
    arst_n = 1'b0;
    tick;
    chk("t4_rst_status", 64'({busy, done, err, s_ready, m_valid, m_last, cpu_enable}), 64'd0);
    chk("t4_rst_ports", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
    chk("t4_rst_mdata", m_data, 64'd0);
    arst_n = 1'b1;
    tick;
    pulse_start(32'd0, 32'd0);
    beat("t4_r_i0", 1'b1, 64'hDEAD_BEEF, 1'b1, 64'd0);
    chk("t4_r_err", 64'(err), 64'd0);
    beat("t4_r_d0", 1'b0, 64'h42, 1'b1, 64'd0);
    chk("t4_r_done", 64'(done), 64'd1);

    // Start pulse during LOAD_DMEM is ignored
    pulse_start(32'd0, 32'd0);
    beat("t5_i0", 1'b1, 64'h13, 1'b1, 64'd0);
    beat("t5_d0", 1'b0, 64'hAB, 1'b0, 64'd0);
    pulse_start(32'd5, 32'd5);
    chk("t5_state", 64'({s_ready, busy, done}), 64'd6);
    beat("t5_d1", 1'b0, 64'hCD, 1'b1, 64'd8);
    chk("t5_done", 64'(done), 64'd1);

    // Dump request larger than dmem is clamped
    pulse_start(32'd0, 32'd2000);
    chk("t6_err", 64'(err), 64'd1);
    beat("t6_i0", 1'b1, 64'h13, 1'b1, 64'd0);
    beat("t6_d0", 1'b0, 64'h1, 1'b1, 64'd0);
    m_ready = 1'b1;
    n = 0;
    words = 0;
    lastpos = 0;
    while (done !== 1'b1 && n < 5000) begin
      if (m_valid === 1'b1) begin
        words++;
        if (m_last === 1'b1) lastpos = words;
      end
      tick;
      n++;
    end
    m_ready = 1'b0;
    chk("t6_words", 64'(words), 64'd1024);
    chk("t6_lastpos", 64'(lastpos), 64'd1024);
    chk("t6_done_err", 64'({done, err}), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
